opb_register_bank_ppc2simulink: RTL and testbench
=================================================

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- C_BASEADDR, 32'h01000000, first byte address of the bank.
- C_HIGHADDR, 32'h010000FF, last byte address of the bank.
- C_NUM_REGS, 8, number of control registers (1..16).
- C_RESET_VAL, 32'h00000000, reset value of every control register.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- OPB_Clk, in, 1, the single clock.
- OPB_Rst, in, 1, reset; asynchronous, active-high.
- OPB_ABus, in, [0:31], byte address.
- OPB_BE, in, [0:3], byte enables; BE[0] selects DBus[0:7].
- OPB_DBus, in, [0:31], write data.
- OPB_RNW, in, 1, 1 = read, 0 = write.
- OPB_select, in, 1, transfer request.
- OPB_seqAddr, in, 1, ignored.
- Sl_DBus, out, [0:31], read data.
- Sl_xferAck, out, 1, transfer complete.
- Sl_errAck, out, 1, error completion.
- Sl_retry, out, 1, tied 0.
- Sl_toutSup, out, 1, tied 0.
- user_data_out, out, C_NUM_REGS*32, active register values.
- user_data_in, in, C_NUM_REGS*32, status words readable by software.
- user_update, out, C_NUM_REGS, one-cycle pulse per register when its active value changes.

Function
REQ-003 The block SHALL map word offset i (0..N-1) to control register i (R/W), word N to COMMIT, and word N+1+i to user_data_in slice i (read-only), where N = C_NUM_REGS.
REQ-004 The block SHALL map OPB bit 0 to bit 31 of each 32-bit slice; slice i SHALL be bits [32i+31:32i].
REQ-005 The block SHALL implement a transfer FSM with states IDLE, DECODE, ACK and HOLD.
- IDLE to DECODE when OPB_select is high and OPB_ABus is within [C_BASEADDR, C_HIGHADDR].
- DECODE to ACK always.
- ACK to HOLD always.
- HOLD to IDLE always.
REQ-006 The block SHALL assert Sl_xferAck (mapped offsets) or Sl_errAck (unmapped in-range offsets, or a write to a read-only word) for exactly one cycle, in ACK only: two cycles after select is sampled in IDLE.
REQ-007 The block SHALL drive Sl_DBus to zero in every cycle except ACK of a mapped read.
REQ-008 The block SHALL write only the byte lanes whose OPB_BE bit is set; the register SHALL update at the end of the ACK cycle.
REQ-009 A control-register read SHALL return the shadow value (COMMIT build) or the active value (non-COMMIT build).
REQ-010 If OPB_select drops before ACK, the block SHALL still complete its FSM sequence, but SHALL suppress the acknowledge and the register write.
REQ-011 A read of COMMIT SHALL return the pending mask in bits [N-1:0], with all other bits 0.

Reset
REQ-012 While OPB_Rst is high, the block SHALL asynchronously force:
- the FSM to IDLE;
- all Sl_* outputs to 0;
- all control registers (shadow and active) to C_RESET_VAL;
- the pending mask to 0;
- user_update to 0.
REQ-013 Reset asserted mid-transfer SHALL abort it with no acknowledge and no register change; the first transfer after reset release SHALL behave per REQ-005.

Configuration
REQ-014 When macro OPB_REGBANK_COMMIT_EN is defined, control-register writes SHALL target shadow registers and set pending bit i.
- A write to COMMIT SHALL copy shadow to active for every i where data bit i AND pending bit i are both 1.
- For each copied register, the block SHALL clear pending bit i and pulse user_update[i] in the following cycle.
REQ-015 When OPB_REGBANK_COMMIT_EN is undefined:
- writes SHALL update the active register directly;
- user_update[i] SHALL pulse the cycle after the write;
- COMMIT SHALL read 0, and writes to it SHALL be acknowledged with no effect.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Write 0xDEADBEEF to offset 0 with BE=1111 -> Sl_xferAck exactly 2 cycles after select; readback returns 0xDEADBEEF.
- Write 0x000000AA to offset 1 with BE=0001 over prior value 0x11223344 -> register reads 0x112233AA.
- COMMIT build: write offsets 0 and 2, then commit data 0x1 -> only slice 0 updates, user_update=0x01, COMMIT reads 0x4.
- Read offset N+1+3 with user_data_in slice 3 = 0x5A5A0000 -> Sl_DBus=0x5A5A0000 in ACK, 0 in every other cycle.
- Write to offset N+1 -> Sl_errAck one cycle, Sl_xferAck 0, no state change.
- Assert OPB_Rst during DECODE -> no acknowledge; all registers read C_RESET_VAL after release.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: N control registers, a COMMIT word and N read-only status words.
// Define OPB_REGBANK_COMMIT_EN to stage writes in shadow registers that a COMMIT write makes active.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR  = 32'h01000000,
    parameter logic [31:0] C_HIGHADDR  = 32'h010000FF,
    parameter int          C_NUM_REGS  = 8,
    parameter logic [31:0] C_RESET_VAL = 32'h00000000
) (
    input  logic                         OPB_Clk,
    input  logic                         OPB_Rst,
    input  logic [0:31]                  OPB_ABus,
    input  logic [0:3]                   OPB_BE,
    input  logic [0:31]                  OPB_DBus,
    input  logic                         OPB_RNW,
    input  logic                         OPB_select,
    input  logic                         OPB_seqAddr,
    output logic [0:31]                  Sl_DBus,
    output logic                         Sl_xferAck,
    output logic                         Sl_errAck,
    output logic                         Sl_retry,
    output logic                         Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]     user_data_out,
    input  logic [C_NUM_REGS*32-1:0]     user_data_in,
    output logic [C_NUM_REGS-1:0]        user_update
);
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACK, S_HOLD} state_t;

    localparam logic [31:0] L_N    = 32'(C_NUM_REGS);
    localparam logic [31:0] L_LAST = 32'(2 * C_NUM_REGS);

    state_t r_state, w_next;

    // OPB bit 0 is the MSB, so a plain vector assignment gives the little-endian view.
    logic [31:0] w_addr, w_wdata, w_wmask, w_off, w_rdata;
    logic [3:0]  w_be;
    logic        w_in_range, w_start, w_ack_en, w_err, w_mapped;
    logic        w_is_ctrl, w_is_commit, w_is_status, w_wr_en;
    logic        w_unused;

    logic [31:0] r_addr;
    logic        r_rnw, r_valid;
    logic [C_NUM_REGS-1:0][31:0] r_active;
    logic [C_NUM_REGS-1:0]       r_update;

    assign w_addr     = OPB_ABus;
    assign w_wdata    = OPB_DBus;
    assign w_be       = OPB_BE;
    assign w_wmask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_in_range = (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_start    = OPB_select && w_in_range;
    assign w_unused   = OPB_seqAddr;

    assign w_off       = (r_addr - C_BASEADDR) >> 2;
    assign w_is_ctrl   = w_off < L_N;
    assign w_is_commit = w_off == L_N;
    assign w_is_status = (w_off > L_N) && (w_off <= L_LAST);
    assign w_mapped    = w_off <= L_LAST;
    assign w_err       = !w_mapped || (!r_rnw && w_is_status);
    // A master that drops select before ACK abandons the transfer silently.
    assign w_ack_en    = r_valid && OPB_select;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_DECODE;
            S_DECODE: w_next = S_ACK;
            S_ACK:    w_next = S_HOLD;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Sl_xferAck = 1'b0;
        Sl_errAck  = 1'b0;
        Sl_DBus    = '0;
        w_wr_en    = 1'b0;
        if (r_state == S_ACK && w_ack_en) begin
            if (w_err) begin
                Sl_errAck = 1'b1;
            end else begin
                Sl_xferAck = 1'b1;
                if (r_rnw) Sl_DBus = w_rdata;
                else       w_wr_en = 1'b1;
            end
        end
    end

    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_addr  <= '0;
            r_rnw   <= 1'b0;
            r_valid <= 1'b0;
        end else if (r_state == S_IDLE && w_start) begin
            r_addr  <= w_addr;
            r_rnw   <= OPB_RNW;
            r_valid <= 1'b1;
        end else if (r_state == S_DECODE && !OPB_select) begin
            r_valid <= 1'b0;
        end
    end

`ifdef OPB_REGBANK_COMMIT_EN
    logic [C_NUM_REGS-1:0][31:0] r_shadow;
    logic [C_NUM_REGS-1:0]       r_pending;
    logic [C_NUM_REGS-1:0]       w_commit_mask;

    assign w_commit_mask = w_wdata[C_NUM_REGS-1:0] & w_wmask[C_NUM_REGS-1:0] & r_pending;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_shadow  <= {C_NUM_REGS{C_RESET_VAL}};
            r_active  <= {C_NUM_REGS{C_RESET_VAL}};
            r_pending <= '0;
            r_update  <= '0;
        end else begin
            r_update <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (w_wr_en && w_off == 32'(i)) begin
                    r_shadow[i]  <= (r_shadow[i] & ~w_wmask) | (w_wdata & w_wmask);
                    r_pending[i] <= 1'b1;
                end
                if (w_wr_en && w_is_commit && w_commit_mask[i]) begin
                    r_active[i]  <= r_shadow[i];
                    r_pending[i] <= 1'b0;
                    r_update[i]  <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_active <= {C_NUM_REGS{C_RESET_VAL}};
            r_update <= '0;
        end else begin
            r_update <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (w_wr_en && w_off == 32'(i)) begin
                    r_active[i] <= (r_active[i] & ~w_wmask) | (w_wdata & w_wmask);
                    r_update[i] <= 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef OPB_REGBANK_COMMIT_EN
            if (w_is_ctrl && w_off == 32'(i)) w_rdata = r_shadow[i];
`else
            if (w_is_ctrl && w_off == 32'(i)) w_rdata = r_active[i];
`endif
            if (w_off == L_N + 32'd1 + 32'(i)) w_rdata = user_data_in[32*i +: 32];
        end
`ifdef OPB_REGBANK_COMMIT_EN
        if (w_is_commit) w_rdata = {{(32-C_NUM_REGS){1'b0}}, r_pending};
`else
        if (w_is_commit) w_rdata = '0;
`endif
    end

    assign user_data_out = r_active;
    assign user_update   = r_update;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for opb_register_bank_ppc2simulink: vector table plus reset, abort and commit sequences.
module tb_opb_register_bank_ppc2simulink;
    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h01000000;

    logic              clk, rst;
    logic [0:31]       abus, dbus, sl_dbus;
    logic [0:3]        be;
    logic              rnw, sel, seq;
    logic              ack, err, retry, tout;
    logic [N*32-1:0]   udo, udi;
    logic [N-1:0]      upd;

    int total = 0;
    int bad   = 0;

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_out(udo), .user_data_in(udi), .user_update(upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One transfer; cycle 0 is the cycle select is driven, ACK is expected in cycle 2.
    task automatic xfer(input logic [31:0] off, input logic r, input logic [3:0] b,
                        input logic [31:0] d, output int ack_cyc, output int n_ack,
                        output int n_err, output logic [31:0] rdata, output int dbus_bad,
                        output logic [N-1:0] upd_after);
        ack_cyc = -1; n_ack = 0; n_err = 0; rdata = '0; dbus_bad = 0; upd_after = '0;
        @(negedge clk);
        abus = BASE + off * 4; rnw = r; be = b; dbus = d; sel = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ack || err) begin
                if (ack_cyc < 0) ack_cyc = k;
                if (ack) n_ack++;
                if (err) n_err++;
                rdata = sl_dbus;
            end else if (sl_dbus != 0) begin
                dbus_bad++;
            end
            if (k == 3) begin
                upd_after = upd;
                sel = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [31:0] off;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] data;
        int          kind;   // 0 none, 1 xferAck, 2 errAck
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[16];

    int          ac, na, ne, db;
    logic [31:0] rd;
    logic [N-1:0] ua;
    logic [31:0] commit_rd;

    initial begin
`ifdef OPB_REGBANK_COMMIT_EN
        commit_rd = 32'h3;
`else
        commit_rd = 32'h0;
`endif
        vecs[0]  = '{32'd0,  1'b0, 4'hF, 32'hDEADBEEF, 1, 32'h0};
        vecs[1]  = '{32'd0,  1'b1, 4'hF, 32'h0,        1, 32'hDEADBEEF};
        vecs[2]  = '{32'd1,  1'b0, 4'hF, 32'h11223344, 1, 32'h0};
        vecs[3]  = '{32'd1,  1'b0, 4'h1, 32'h000000AA, 1, 32'h0};
        vecs[4]  = '{32'd1,  1'b1, 4'hF, 32'h0,        1, 32'h112233AA};
        vecs[5]  = '{32'd8,  1'b1, 4'hF, 32'h0,        1, commit_rd};
        vecs[6]  = '{32'd12, 1'b1, 4'hF, 32'h0,        1, 32'h5A5A0000};
        vecs[7]  = '{32'd9,  1'b0, 4'hF, 32'hFFFFFFFF, 2, 32'h0};
        vecs[8]  = '{32'd0,  1'b1, 4'hF, 32'h0,        1, 32'hDEADBEEF};
        vecs[9]  = '{32'd9,  1'b1, 4'hF, 32'h0,        1, 32'h10000000};
        vecs[10] = '{32'd17, 1'b1, 4'hF, 32'h0,        2, 32'h0};
        vecs[11] = '{32'd5,  1'b0, 4'hC, 32'hCAFE1234, 1, 32'h0};
        vecs[12] = '{32'd5,  1'b1, 4'hF, 32'h0,        1, 32'hCAFE0000};
        vecs[13] = '{32'd64, 1'b1, 4'hF, 32'h0,        0, 32'h0};
        vecs[14] = '{32'd7,  1'b0, 4'h0, 32'h12345678, 1, 32'h0};
        vecs[15] = '{32'd7,  1'b1, 4'hF, 32'h0,        1, 32'h0};

        for (int i = 0; i < N; i++) udi[32*i +: 32] = 32'h10000000 + 32'(i);
        udi[32*3 +: 32] = 32'h5A5A0000;
        abus = '0; dbus = '0; be = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_acks", {30'd0, ack, err}, 32'h0);
        check("rst_retry_tout", {30'd0, retry, tout}, 32'h0);
        check("rst_dbus", sl_dbus, 32'h0);
        check("rst_update", 32'(upd), 32'h0);
        check("rst_udo_lo", udo[31:0], 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].off, vecs[i].rnw, vecs[i].be, vecs[i].data, ac, na, ne, rd, db, ua);
            check($sformatf("v%0d_ack_cycle", i), 32'(ac), (vecs[i].kind == 0) ? 32'hFFFFFFFF : 32'd2);
            check($sformatf("v%0d_xferack", i), 32'(na), (vecs[i].kind == 1) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_errack", i), 32'(ne), (vecs[i].kind == 2) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_dbus_idle", i), 32'(db), 32'd0);
            if (vecs[i].rnw) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // Reset asserted during DECODE of a write
        @(negedge clk);
        abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'h99999999; sel = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_acks", {30'd0, ack, err}, 32'h0);
        sel = 1'b0;
        @(negedge clk);
        check("rst_mid_acks2", {30'd0, ack, err}, 32'h0);
        check("rst_mid_update", 32'(upd), 32'h0);
        check("rst_mid_udo0", udo[31:0], 32'h0);
        check("rst_mid_udo1", udo[63:32], 32'h0);
        rst = 1'b0;
        na = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack || err) na++;
        end
        check("rst_mid_no_ack", 32'(na), 32'd0);
        for (int i = 0; i < N; i++) begin
            xfer(32'(i), 1'b1, 4'hF, 32'h0, ac, na, ne, rd, db, ua);
            check($sformatf("post_rst_ack_cycle%0d", i), 32'(ac), 32'd2);
            check($sformatf("post_rst_reg%0d", i), rd, 32'h0);
        end

        // Select dropped in DECODE: sequence completes without ack or write
        @(negedge clk);
        abus = BASE + 32'd28; rnw = 1'b0; be = 4'hF; dbus = 32'h13579BDF; sel = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        na = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack || err) na++;
        end
        check("abort_no_ack", 32'(na), 32'd0);
        xfer(32'd7, 1'b1, 4'hF, 32'h0, ac, na, ne, rd, db, ua);
        check("abort_next_ack_cycle", 32'(ac), 32'd2);
        check("abort_reg7", rd, 32'h0);

`ifdef OPB_REGBANK_COMMIT_EN
        xfer(32'd0, 1'b0, 4'hF, 32'h11111111, ac, na, ne, rd, db, ua);
        check("c_wr0_update", 32'(ua), 32'h0);
        xfer(32'd2, 1'b0, 4'hF, 32'h22222222, ac, na, ne, rd, db, ua);
        check("c_wr2_update", 32'(ua), 32'h0);
        check("c_active0_before", udo[31:0], 32'h0);
        xfer(32'd8, 1'b0, 4'hF, 32'h00000001, ac, na, ne, rd, db, ua);
        check("c_commit_ack", 32'(na), 32'd1);
        check("c_commit_update", 32'(ua), 32'h01);
        check("c_active0", udo[31:0], 32'h11111111);
        check("c_active2", udo[95:64], 32'h0);
        xfer(32'd8, 1'b1, 4'hF, 32'h0, ac, na, ne, rd, db, ua);
        check("c_pending", rd, 32'h4);
        xfer(32'd2, 1'b1, 4'hF, 32'h0, ac, na, ne, rd, db, ua);
        check("c_shadow2", rd, 32'h22222222);
`else
        xfer(32'd2, 1'b0, 4'hF, 32'h22222222, ac, na, ne, rd, db, ua);
        check("d_wr2_update", 32'(ua), 32'h04);
        check("d_active2", udo[95:64], 32'h22222222);
        check("d_active0", udo[31:0], 32'h0);
        xfer(32'd8, 1'b0, 4'hF, 32'h00000001, ac, na, ne, rd, db, ua);
        check("d_commit_ack", 32'(na), 32'd1);
        check("d_commit_update", 32'(ua), 32'h0);
        xfer(32'd8, 1'b1, 4'hF, 32'h0, ac, na, ne, rd, db, ua);
        check("d_commit_read", rd, 32'h0);
        check("d_active2_kept", udo[95:64], 32'h22222222);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
